// File: rtl/axi_node_pkg.sv
// Shared types for the AXI node write-address path.
package axi_node_pkg;

  typedef enum logic [1:0] {
    OPERATIVE = 2'd0,
    ERR_DRAIN = 2'd1,
    ERR_REQ   = 2'd2,
    ERR_WAIT  = 2'd3
  } aw_dec_state_e;

endpackage

// File: rtl/axi_aw_route_fifo.sv
// Synchronous FIFO of AW route entries; head steers the W channel.
module axi_aw_route_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  entry_t          r_mem [DEPTH];
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_count == (PtrW + 1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PtrW + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= entry_i;
  end

endmodule

// File: rtl/axi_aw_route_decoder.sv
// AW address decoder/router for one target port; steers W bursts in AW order
// and sequences decode-error responses with the B-channel allocator.
module axi_aw_route_decoder
  import axi_node_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = 1,
  parameter int unsigned N_REGION    = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   awvalid_i,
  input  logic [ADDR_W-1:0]                      awaddr_i,
  output logic                                   awready_o,
  output logic [N_INIT_PORT-1:0]                 awvalid_o,
  input  logic [N_INIT_PORT-1:0]                 awready_i,
  input  logic                                   wvalid_i,
  input  logic                                   wlast_i,
  output logic                                   wready_o,
  output logic [N_INIT_PORT-1:0]                 wvalid_o,
  input  logic [N_INIT_PORT-1:0]                 wready_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_W-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_W-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]        enable_region_i,
  input  logic [N_INIT_PORT-1:0]                 connectivity_map_i,
  output logic                                   incr_req_o,
  input  logic                                   full_counter_i,
  input  logic                                   outstanding_trans_i,
  output logic                                   sample_awdata_info_o,
  output logic                                   error_req_o,
  input  logic                                   error_gnt_i
);

  typedef struct packed {
    logic                   err;
    logic [N_INIT_PORT-1:0] sel;
  } route_entry_t;

  aw_dec_state_e    r_state;
  logic             r_error_req;
  logic [N_INIT_PORT-1:0] w_hit;
  logic [N_INIT_PORT-1:0] w_sel;
  logic             w_dec_err;
  logic             w_aw_open;
  logic             w_awready;
  logic             w_wready;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  route_entry_t     w_push_entry;
  route_entry_t     w_head;
  logic             w_unused;

  // Grant timing is owned by the allocator; this input is informational only.
  assign w_unused = outstanding_trans_i;

  always_comb begin
    w_hit = '0;
    for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
      for (int unsigned r = 0; r < N_REGION; r++) begin
        if (enable_region_i[r*N_INIT_PORT+p] &&
            awaddr_i >= START_ADDR_i[(r*N_INIT_PORT+p)*ADDR_W +: ADDR_W] &&
            awaddr_i <= END_ADDR_i[(r*N_INIT_PORT+p)*ADDR_W +: ADDR_W]) begin
          w_hit[p] = w_hit[p] | connectivity_map_i[p];
        end
      end
    end
  end

  // Lowest-numbered initiator wins when regions overlap.
  always_comb begin
    w_sel = '0;
    for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
      if (w_hit[p]) begin
        w_sel    = '0;
        w_sel[p] = 1'b1;
      end
    end
  end

  assign w_dec_err = ~|w_hit;
  assign w_aw_open = awvalid_i & (r_state == OPERATIVE) & ~w_fifo_full;
  assign w_awready = w_dec_err ? w_aw_open
                               : (w_aw_open & ~full_counter_i & |(awready_i & w_sel));

  assign awready_o            = w_awready;
  assign awvalid_o            = (w_aw_open & ~w_dec_err & ~full_counter_i) ? w_sel : '0;
  assign incr_req_o           = w_awready & ~w_dec_err;
  assign sample_awdata_info_o = w_awready & w_dec_err;

  assign w_push_entry.err = w_dec_err;
  assign w_push_entry.sel = w_sel;

  // Errored bursts are accepted and discarded so the target port never stalls.
  assign w_wready = ~w_fifo_empty & (w_head.err | |(wready_i & w_head.sel));
  assign wready_o = w_wready;
  assign wvalid_o = (~w_fifo_empty & ~w_head.err & wvalid_i) ? w_head.sel : '0;
  assign w_pop    = wvalid_i & w_wready & wlast_i;

  axi_aw_route_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (route_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_awready),
    .entry_i (w_push_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign error_req_o = r_error_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OPERATIVE;
      r_error_req <= 1'b0;
    end else begin
      unique case (r_state)
        OPERATIVE: if (w_awready && w_dec_err) r_state <= ERR_DRAIN;
        ERR_DRAIN: begin
          if (w_pop && w_head.err) begin
            r_state     <= ERR_REQ;
            r_error_req <= 1'b1;
          end
        end
        ERR_REQ: begin
          if (error_gnt_i) begin
            r_state     <= ERR_WAIT;
            r_error_req <= 1'b0;
          end
        end
        // AW stays blocked so the sampled id/user hold while the error B is presented.
        ERR_WAIT: if (!error_gnt_i) r_state <= OPERATIVE;
        default: r_state <= OPERATIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_route_decoder.sv
// Directed plus randomized bench for axi_aw_route_decoder with a queue-based route model.
module tb_axi_aw_route_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid_i;
  logic [31:0]  awaddr_i;
  logic         awready_o;
  logic [1:0]   awvalid_o;
  logic [1:0]   awready_i;
  logic         wvalid_i;
  logic         wlast_i;
  logic         wready_o;
  logic [1:0]   wvalid_o;
  logic [1:0]   wready_i;
  logic [127:0] start_bus;
  logic [127:0] end_bus;
  logic [3:0]   en_reg;
  logic [1:0]   conn;
  logic         incr_req_o;
  logic         full_counter_i;
  logic         outstanding_i;
  logic         sample_o;
  logic         error_req_o;
  logic         error_gnt_i;

  logic [31:0]  m_start [4];
  logic [31:0]  m_end   [4];
  int           q[$];
  bit           m_blocked;
  int           n_chk;
  int           n_pass;

  always #5 clk = ~clk;

  always_comb begin
    start_bus = '0;
    end_bus   = '0;
    for (int i = 0; i < 4; i++) begin
      start_bus[i*32 +: 32] = m_start[i];
      end_bus[i*32 +: 32]   = m_end[i];
    end
  end

  axi_aw_route_decoder #(
    .N_INIT_PORT (2),
    .N_REGION    (2),
    .ADDR_W      (32),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .awvalid_i            (awvalid_i),
    .awaddr_i             (awaddr_i),
    .awready_o            (awready_o),
    .awvalid_o            (awvalid_o),
    .awready_i            (awready_i),
    .wvalid_i             (wvalid_i),
    .wlast_i              (wlast_i),
    .wready_o             (wready_o),
    .wvalid_o             (wvalid_o),
    .wready_i             (wready_i),
    .START_ADDR_i         (start_bus),
    .END_ADDR_i           (end_bus),
    .enable_region_i      (en_reg),
    .connectivity_map_i   (conn),
    .incr_req_o           (incr_req_o),
    .full_counter_i       (full_counter_i),
    .outstanding_trans_i  (outstanding_i),
    .sample_awdata_info_o (sample_o),
    .error_req_o          (error_req_o),
    .error_gnt_i          (error_gnt_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Returns the initiator port for an address, or -1 on a decode miss.
  function automatic int ref_route(input logic [31:0] a);
    for (int p = 0; p < 2; p++) begin
      if (conn[p]) begin
        for (int r = 0; r < 2; r++) begin
          if (en_reg[r*2+p] && a >= m_start[r*2+p] && a <= m_end[r*2+p]) return p;
        end
      end
    end
    return -1;
  endfunction

  // Checks every routing output for the current inputs, then advances one clock.
  task automatic cyc_check(input string tag);
    int         r;
    int         h;
    bit         open_aw;
    logic [1:0] e_awv;
    logic       e_awr;
    logic [1:0] e_wv;
    logic       e_wr;
    r       = ref_route(awaddr_i);
    open_aw = awvalid_i && !m_blocked && (q.size() < 8);
    e_awv   = (open_aw && r >= 0 && !full_counter_i) ? (2'b01 << r) : 2'b00;
    e_awr   = (r < 0) ? open_aw : (open_aw && !full_counter_i && awready_i[r]);
    h       = (q.size() > 0) ? q[0] : -2;
    e_wv    = (q.size() > 0 && h >= 0 && wvalid_i) ? (2'b01 << h) : 2'b00;
    e_wr    = (q.size() > 0) && (h < 0 || wready_i[h]);
    #1;
    chk({tag, "_awvalid"}, awvalid_o, e_awv);
    chk({tag, "_awready"}, awready_o, e_awr);
    chk({tag, "_incr"}, incr_req_o, e_awr && r >= 0);
    chk({tag, "_sample"}, sample_o, e_awr && r < 0);
    chk({tag, "_wvalid"}, wvalid_o, e_wv);
    chk({tag, "_wready"}, wready_o, e_wr);
    @(posedge clk);
    #1;
    if (wvalid_i && e_wr && wlast_i) void'(q.pop_front());
    if (e_awr) q.push_back(r);
    if (e_awr && r < 0) m_blocked = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_blocked = 1'b0;
    rst_n = 1'b0; awvalid_i = 0; awaddr_i = 0; awready_i = 0;
    wvalid_i = 0; wlast_i = 0; wready_i = 0; full_counter_i = 0;
    outstanding_i = 0; error_gnt_i = 0; conn = 2'b11; en_reg = 4'b0011;
    m_start[0] = 32'h0;    m_end[0] = 32'h0FFF;
    m_start[1] = 32'h1000; m_end[1] = 32'h1FFF;
    m_start[2] = 32'h0;    m_end[2] = 32'h0;
    m_start[3] = 32'h0;    m_end[3] = 32'h0;
    #3;
    chk("rst_awready", awready_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wready", wready_o, 0);
    chk("rst_error_req", error_req_o, 0);
    chk("rst_incr", incr_req_o, 0);
    chk("rst_sample", sample_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Routed AW to p1 followed by a 4-beat burst
    awvalid_i = 1; awaddr_i = 32'h1004; awready_i = 2'b11; wready_i = 2'b11;
    #1 chk("t1_awvalid_p1", awvalid_o, 2'b10);
    cyc_check("t1_aw");
    awvalid_i = 0;
    for (int i = 0; i < 4; i++) begin
      wvalid_i = 1; wlast_i = (i == 3);
      cyc_check("t1_w");
    end
    wvalid_i = 0; wlast_i = 0;
    #1 chk("t1_fifo_empty", wready_o, 0);

    // Decode miss: drain, request, grant, then unblock
    awvalid_i = 1; awaddr_i = 32'h8000;
    #1 chk("t2_sample", sample_o, 1);
    cyc_check("t2_miss");
    awaddr_i = 32'h10;
    for (int i = 0; i < 2; i++) begin
      wvalid_i = 1; wlast_i = (i == 1);
      cyc_check("t2_drop");
    end
    wvalid_i = 0; wlast_i = 0;
    chk("t2_req_set", error_req_o, 1);
    cyc_check("t2_req_hold");
    chk("t2_req_still", error_req_o, 1);
    error_gnt_i = 1;
    @(posedge clk); #1;
    chk("t2_req_fall", error_req_o, 0);
    cyc_check("t2_gnt_a");
    cyc_check("t2_gnt_b");
    chk("t2_req_low", error_req_o, 0);
    error_gnt_i = 0;
    cyc_check("t2_wait");
    m_blocked = 1'b0;
    cyc_check("t2_resume");
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    cyc_check("t2_w");
    wvalid_i = 0; wlast_i = 0;

    // Overlap priority and connectivity masking
    en_reg[3] = 1; m_start[3] = 32'h0; m_end[3] = 32'h01FF;
    awvalid_i = 1; awaddr_i = 32'h100; awready_i = 2'b00;
    #1 chk("t3_overlap_p0", awvalid_o, 2'b01);
    conn = 2'b10;
    #1 chk("t3_conn_p1", awvalid_o, 2'b10);
    awvalid_i = 0; conn = 2'b11; en_reg[3] = 0; awready_i = 2'b11;
    #1;

    // Fill the FIFO, then release W one burst at a time
    for (int i = 0; i < 8; i++) begin
      awvalid_i = 1; awaddr_i = (i % 2 == 1) ? (32'h1000 + i * 4) : (i * 4);
      cyc_check("t4_fill");
    end
    awaddr_i = 32'h1800;
    #1 chk("t4_full_awready", awready_o, 0);
    chk("t4_full_awvalid", awvalid_o, 0);
    for (int j = 0; j < 9; j++) begin
      wvalid_i = 1; wlast_i = 1;
      cyc_check("t4_drain");
      if (j == 1) awvalid_i = 0;
    end
    wvalid_i = 0; wlast_i = 0;
    #1 chk("t4_empty", wready_o, 0);

    // Allocator counter saturated
    full_counter_i = 1; awvalid_i = 1; awaddr_i = 32'h1004;
    #1 chk("t5_awvalid_blk", awvalid_o, 0);
    chk("t5_incr_blk", incr_req_o, 0);
    cyc_check("t5_sat");
    full_counter_i = 0;
    cyc_check("t5_go");
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    cyc_check("t5_w");
    wvalid_i = 0; wlast_i = 0;

    // Randomized traffic, hit addresses only
    for (int i = 0; i < 300; i++) begin
      awvalid_i      = 1'($urandom % 2);
      awaddr_i       = $urandom_range(0, 32'h1FFF);
      awready_i      = 2'($urandom);
      wready_i       = 2'($urandom);
      wvalid_i       = 1'($urandom % 2);
      wlast_i        = ($urandom % 3 == 0);
      full_counter_i = ($urandom % 4 == 0);
      cyc_check("rnd");
    end
    awvalid_i = 0; full_counter_i = 0; wready_i = 2'b11; wvalid_i = 1; wlast_i = 1;
    for (int n = 0; n < 20 && q.size() > 0; n++) cyc_check("rnd_drain");
    wvalid_i = 0; wlast_i = 0;
    #1 chk("rnd_empty", wready_o, 0);

    // Reset during ERR_REQ
    awvalid_i = 1; awaddr_i = 32'h8000;
    cyc_check("t6_miss");
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    cyc_check("t6_drop");
    wvalid_i = 0; wlast_i = 0;
    chk("t6_req_before", error_req_o, 1);
    rst_n = 0;
    #1 chk("t6_req_async", error_req_o, 0);
    q.delete(); m_blocked = 1'b0;
    @(posedge clk); #1 rst_n = 1;

    // Reset mid-burst
    awvalid_i = 1; awaddr_i = 32'h1004;
    cyc_check("t6_aw");
    awvalid_i = 0; wvalid_i = 1; wlast_i = 0;
    cyc_check("t6_beat");
    rst_n = 0;
    #1 chk("t6_wvalid_async", wvalid_o, 0);
    chk("t6_wready_async", wready_o, 0);
    q.delete();
    @(posedge clk); #1 rst_n = 1;
    #1 chk("t6_flushed", wready_o, 0);
    wvalid_i = 0;
    awvalid_i = 1; awaddr_i = 32'h10;
    cyc_check("t6_operative");
    awvalid_i = 0; wvalid_i = 1; wlast_i = 1;
    cyc_check("t6_w");
    wvalid_i = 0; wlast_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
